regfile_dual_bank_sb: RTL

//  Parametrised integer + floating-point register file with explicit 2R/1W ports and a per-register

---
 rtl/regfile_dual_bank_sb_if.sv | 25 ++
 rtl/regfile_dual_bank_sb.sv | 63 ++++++
 2 files changed

// File: rtl/regfile_dual_bank_sb_if.sv
// regfile_dual_bank_sb_if: decode/issue/writeback bus of the dual-bank register file
//   read  : rs1/rs2 _addr,_fp -> rs1/rs2 _data,_busy
//   issue : iss_en, iss_addr, iss_fp -> iss_conflict
//   wb    : wb_en, wb_addr, wb_fp, wb_data
//   master = pipeline side, slave = register file side
interface regfile_dual_bank_sb_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);
  logic [AW-1:0]   rs1_addr, rs2_addr, iss_addr, wb_addr;
  logic            rs1_fp, rs2_fp, iss_en, iss_fp, wb_en, wb_fp;
  logic [XLEN-1:0] rs1_data, rs2_data, wb_data;
  logic            rs1_busy, rs2_busy, iss_conflict;
  modport master (
    output rs1_addr, rs1_fp, rs2_addr, rs2_fp, iss_en, iss_addr, iss_fp,
           wb_en, wb_addr, wb_fp, wb_data,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, iss_conflict
  );
  modport slave (
    input  rs1_addr, rs1_fp, rs2_addr, rs2_fp, iss_en, iss_addr, iss_fp,
           wb_en, wb_addr, wb_fp, wb_data,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, iss_conflict
  );
endinterface

// File: rtl/regfile_dual_bank_sb.sv
// regfile_dual_bank_sb: int + fp register banks, 2R/1W, per-register busy scoreboard
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears both banks and all busy bits
//   bus   : regfile_dual_bank_sb_if.slave (read ports, issue port, writeback port)
//   REGFILE_BYPASS_EN : when defined, a same-cycle writeback is forwarded to matching read ports
module regfile_dual_bank_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input logic clk,
  input logic rst_n,
  regfile_dual_bank_sb_if.slave bus
);
  logic [XLEN-1:0] x_q [NREG];
  logic [XLEN-1:0] f_q [NREG];
  logic [NREG-1:0] xb_q, fb_q, xb_d, fb_d;
  logic [XLEN-1:0] rd1, rd2;
  logic            bz1, bz2, hit1, hit2, wb_ok;
  // x0 is never written, so it keeps its reset value of zero
  assign wb_ok = bus.wb_en && (bus.wb_fp || bus.wb_addr != '0);
  // clear on writeback first, then set on issue so a same-edge issue wins
  always_comb begin
    xb_d = xb_q;
    fb_d = fb_q;
    if (wb_ok && bus.wb_fp) fb_d[bus.wb_addr] = 1'b0;
    if (wb_ok && !bus.wb_fp) xb_d[bus.wb_addr] = 1'b0;
    if (bus.iss_en && bus.iss_fp) fb_d[bus.iss_addr] = 1'b1;
    if (bus.iss_en && !bus.iss_fp) xb_d[bus.iss_addr] = 1'b1;
    xb_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        x_q[i] <= '0;
        f_q[i] <= '0;
      end
      xb_q <= '0;
      fb_q <= '0;
    end else begin
      xb_q <= xb_d;
      fb_q <= fb_d;
      if (wb_ok && bus.wb_fp) f_q[bus.wb_addr] <= bus.wb_data;
      if (wb_ok && !bus.wb_fp) x_q[bus.wb_addr] <= bus.wb_data;
    end
  end
  assign rd1 = bus.rs1_fp ? f_q[bus.rs1_addr] : x_q[bus.rs1_addr];
  assign rd2 = bus.rs2_fp ? f_q[bus.rs2_addr] : x_q[bus.rs2_addr];
  assign bz1 = bus.rs1_fp ? fb_q[bus.rs1_addr] : xb_q[bus.rs1_addr];
  assign bz2 = bus.rs2_fp ? fb_q[bus.rs2_addr] : xb_q[bus.rs2_addr];
`ifdef REGFILE_BYPASS_EN
  // gated by rst_n so outputs read zero while reset is held
  assign hit1 = rst_n && wb_ok && bus.wb_fp == bus.rs1_fp && bus.wb_addr == bus.rs1_addr;
  assign hit2 = rst_n && wb_ok && bus.wb_fp == bus.rs2_fp && bus.wb_addr == bus.rs2_addr;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  assign bus.rs1_data = hit1 ? bus.wb_data : rd1;
  assign bus.rs2_data = hit2 ? bus.wb_data : rd2;
  assign bus.rs1_busy = !hit1 && bz1;
  assign bus.rs2_busy = !hit2 && bz2;
  assign bus.iss_conflict = bus.iss_en && (bus.iss_fp ? fb_q[bus.iss_addr] : xb_q[bus.iss_addr]);
endmodule
